// File: rtl/led_trail_fader.sv
// led_trail_fader: per-LED PWM driver that turns the chaser's LED request
// vector into a "comet tail". A requested LED runs at full brightness; once
// released, its level steps down linearly on every decay tick until dark.
module led_trail_fader #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 196,
  parameter int DECAY_DIV  = 390625,
  parameter int DECAY_STEP = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] led_i,
  output logic [3:0] led_o,
  output logic       pwm_sync_o
);

  localparam int NUM_LED = 4;
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DEC_W   = $clog2(DECAY_DIV);

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  // The PWM counter stops one short of MAX so that level == MAX stays lit all period.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DEC_W-1:0]    DEC_LAST = DEC_W'(DECAY_DIV - 1);

  logic [PRE_W-1:0]                   pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [DEC_W-1:0]                   dec_cnt_q, dec_cnt_d;
  logic [NUM_LED-1:0][PWM_BITS-1:0]   level_q, level_d;
  logic [NUM_LED-1:0]                 led_o_q, led_o_d;
  logic                               pwm_sync_q, pwm_sync_d;

  logic pwm_step;
  logic decay_tick;

  // Free-running timebases: PWM prescaler, PWM counter and decay divider.
  always_comb begin
    pwm_step   = (pre_cnt_q == PRE_LAST);
    decay_tick = (dec_cnt_q == DEC_LAST);

    pre_cnt_d = pwm_step ? '0 : pre_cnt_q + PRE_W'(1);

    pwm_cnt_d = pwm_cnt_q;
    if (pwm_step) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    end

    // Registered, so the pulse lines up with the first cycle of pwm_cnt == 0.
    pwm_sync_d = pwm_step && (pwm_cnt_q == PWM_LAST);

    dec_cnt_d = decay_tick ? '0 : dec_cnt_q + DEC_W'(1);
  end

  // Per-LED brightness: a request loads full scale (and beats a coincident tick),
  // otherwise the level decays with saturation at zero.
  always_comb begin
    level_d = level_q;
    for (int n = 0; n < NUM_LED; n++) begin
      if (led_i[n]) begin
        level_d[n] = LVL_MAX;
      end else if (decay_tick) begin
        level_d[n] = (level_q[n] > STEP) ? level_q[n] - STEP : '0;
      end
    end
  end

  // PWM compare against the current level, gated by the output enable.
  always_comb begin
    led_o_d = '0;
    for (int n = 0; n < NUM_LED; n++) begin
      led_o_d[n] = en & (pwm_cnt_q < level_q[n]);
    end
  end

  // State registers; reset clears everything, including any fade in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      dec_cnt_q  <= '0;
      level_q    <= '0;
      led_o_q    <= '0;
      pwm_sync_q <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      level_q    <= level_d;
      led_o_q    <= led_o_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end

  assign led_o      = led_o_q;
  assign pwm_sync_o = pwm_sync_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: directed scenarios with duty measurements plus a
// randomized phase, all outputs also compared every cycle against a
// time-indexed reference model of brightness levels.
module tb_led_trail_fader;

  localparam int PWM_BITS   = 4;
  localparam int MAX        = 15;
  localparam int PRESCALE   = 1;
  localparam int DECAY_DIV  = 60;
  localparam int DECAY_STEP = 4;
  localparam int PERIOD     = MAX * PRESCALE;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] led_i = 4'hF;
  logic [3:0] led_o;
  logic       pwm_sync_o;

  int n_tests = 0;
  int n_fail  = 0;

  led_trail_fader #(
    .PWM_BITS  (PWM_BITS),
    .PRESCALE  (PRESCALE),
    .DECAY_DIV (DECAY_DIV),
    .DECAY_STEP(DECAY_STEP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .led_i     (led_i),
    .led_o     (led_o),
    .pwm_sync_o(pwm_sync_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: t = clk edges since reset release. PWM position and decay
  // ticks follow from t by plain arithmetic; levels follow the load/decay rules.
  int         t = 0;
  int         lvl [4] = '{0, 0, 0, 0};
  logic [3:0] exp_led  = 4'h0;
  logic       exp_sync = 1'b0;

  // Advance the model one edge, using the values present just before the edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t        <= 0;
      lvl      <= '{0, 0, 0, 0};
      exp_led  <= 4'h0;
      exp_sync <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        exp_led[n] <= en && (((t / PRESCALE) % MAX) < lvl[n]);
        if (led_i[n])
          lvl[n] <= MAX;
        else if ((t % DECAY_DIV) == DECAY_DIV - 1)
          lvl[n] <= (lvl[n] > DECAY_STEP) ? lvl[n] - DECAY_STEP : 0;
      end
      exp_sync <= (t % PERIOD) == PERIOD - 1;
      t <= t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_eq("led_o_model", int'(led_o), int'(exp_led));
    check_eq("sync_model", int'(pwm_sync_o), int'(exp_sync));
  end

  int cnt [4];

  task automatic wait_sync();
    int k = 0;
    while (!pwm_sync_o && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    check_eq("sync_seen", int'(pwm_sync_o), 1);
  endtask

  // Count high cycles per LED over one full PWM period following a sync pulse.
  task automatic measure();
    for (int n = 0; n < 4; n++) cnt[n] = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) cnt[n] += int'(led_o[n]);
    end
  endtask

  task automatic align_to(input int m, input int r);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((t % m) != r && k <= m);
    check_eq("align", t % m, r);
  endtask

  int fade_exp [17] = '{15, 15, 15, 11, 11, 11, 11, 7, 7, 7, 7, 3, 3, 3, 3, 0, 0};
  int marq_exp [4]  = '{3, 7, 11, 15};
  int npulse;
  int last_pulse;

  initial begin
    // Reset with all requests high: outputs must stay quiet.
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_led", int'(led_o), 0);
      check_eq("rst_sync", int'(pwm_sync_o), 0);
    end
    led_i = 4'h0;
    en    = 1'b1;
    rstn  = 1'b1;

    npulse     = 0;
    last_pulse = -1;
    repeat (200) begin
      @(negedge clk);
      check_eq("idle_led", int'(led_o), 0);
      if (pwm_sync_o) begin
        if (last_pulse >= 0) check_eq("sync_period", t - last_pulse, PERIOD);
        last_pulse = t;
        npulse++;
      end
    end
    check_eq("sync_count", npulse, 13);

    // Steady on: two-edge latency, then full duty.
    led_i = 4'b0001;
    @(negedge clk);
    check_eq("on_lat1", int'(led_o[0]), 0);
    @(negedge clk);
    check_eq("on_lat2", int'(led_o[0]), 1);
    wait_sync();
    measure();
    check_eq("on_duty", cnt[0], 15);
    check_eq("on_others", cnt[1] + cnt[2] + cnt[3], 0);

    // Fade: one-cycle request right after a tick, then measure every period.
    led_i = 4'h0;
    align_to(DECAY_DIV, 0);
    led_i = 4'b0010;
    @(negedge clk);
    led_i = 4'h0;
    for (int p = 0; p < 17; p++) begin
      wait_sync();
      measure();
      check_eq($sformatf("fade_p%0d", p), cnt[1], fade_exp[p]);
    end

    // Load beats decay: re-request LED2 in the tick cycle while its level is 7.
    align_to(DECAY_DIV, 0);
    led_i = 4'b0100;
    @(negedge clk);
    led_i = 4'h0;
    repeat (3) align_to(DECAY_DIV, DECAY_DIV - 1);
    led_i = 4'b0100;
    @(negedge clk);
    led_i = 4'h0;
    wait_sync();
    measure();
    check_eq("load_wins", cnt[2], 15);

    // Enable: drop en at level 11, hold 120 cycles, resume at level 3.
    align_to(DECAY_DIV, 0);
    led_i = 4'b1000;
    @(negedge clk);
    led_i = 4'h0;
    align_to(DECAY_DIV, 5);
    align_to(DECAY_DIV, 5);
    en = 1'b0;
    repeat (120) begin
      @(negedge clk);
      check_eq("en_off", int'(led_o), 0);
    end
    en = 1'b1;
    wait_sync();
    measure();
    check_eq("en_resume", cnt[3], 3);

    // Marquee: four tick-aligned phases of 60 cycles, then measure the trail.
    align_to(DECAY_DIV, 0);
    led_i = 4'b0001;
    align_to(DECAY_DIV, 0);
    led_i = 4'b0010;
    align_to(DECAY_DIV, 0);
    led_i = 4'b0100;
    align_to(DECAY_DIV, 0);
    led_i = 4'b1000;
    align_to(DECAY_DIV, 0);
    wait_sync();
    measure();
    for (int n = 0; n < 4; n++) check_eq($sformatf("marquee_led%0d", n), cnt[n], marq_exp[n]);

    // Randomized requests and enable, checked by the per-cycle model compare.
    repeat (600) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) led_i[b] = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 15) != 0);
    end

    // Reset mid-fade: outputs clear immediately and levels are discarded.
    @(negedge clk);
    en    = 1'b1;
    led_i = 4'hF;
    @(negedge clk);
    led_i = 4'h0;
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("midrst_led", int'(led_o), 0);
    check_eq("midrst_sync", int'(pwm_sync_o), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check_eq("post_rst_led", int'(led_o), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
